// File: rtl/ras_stack_pkg.sv
// Shared fetch-stage constants and the RAS pointer type, also used by the
// branch ordering buffer so the checkpointed rasptr field stays width-locked.
package ras_stack_pkg;
    localparam int RAS_DEPTH    = 16;
    localparam int RAS_LOGDEPTH = 4;
    localparam int FETCH_AW     = 64;

    typedef logic [RAS_LOGDEPTH-1:0] rasptr_t;
endpackage

// File: rtl/ras_stack_ram_dp.sv
// Dual-port RAM wrapper: one combinational read port, one synchronous write
// port, contents cleared by the asynchronous reset.
module ram_dp #(
    parameter int DEPTH    = 16,
    parameter int LOGDEPTH = 4,
    parameter int AW       = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_we,
    input  logic [LOGDEPTH-1:0] i_waddr,
    input  logic [AW-1:0]       i_wdata,
    input  logic [LOGDEPTH-1:0] i_raddr,
    output logic [AW-1:0]       o_rdata
);
    logic [AW-1:0] r_mem [DEPTH];

    // storage array: cleared on reset, single write per cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {AW{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ras_stack.sv
// Return Address Stack beside the F1 PC mux. Optional macro RAS_TOP_REPAIR_EN
// adds restore_tgt_i so a restore also rewrites the entry it rewinds to.
module ras_stack
    import ras_stack_pkg::*;
#(
    parameter int DEPTH    = RAS_DEPTH,
    parameter int LOGDEPTH = RAS_LOGDEPTH,
    parameter int AW       = FETCH_AW
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [AW-1:0]       push_addr_i,
    input  logic                restore_i,
    input  logic [LOGDEPTH-1:0] restore_ptr_i,
`ifdef RAS_TOP_REPAIR_EN
    input  logic [AW-1:0]       restore_tgt_i,
`endif
    output logic [LOGDEPTH-1:0] ras_ptr_o,
    output logic [AW-1:0]       ras_tgt_o,
    output logic                ras_valid_o,
    output logic                ras_ovf_o
);
    logic [LOGDEPTH-1:0] r_tos;
    logic [DEPTH-1:0]    r_vld;
    logic                r_ovf;

    logic [LOGDEPTH-1:0] w_tos_inc;
    logic [LOGDEPTH-1:0] w_tos_nxt;
    logic                w_we;
    logic [LOGDEPTH-1:0] w_waddr;
    logic [AW-1:0]       w_wdata;
    logic                w_ovf_set;

    assign w_tos_inc = r_tos + LOGDEPTH'(1);

    // next-state decode in priority order: restore, coroutine, push, pop
    always_comb begin
        w_tos_nxt = r_tos;
        w_we      = 1'b0;
        w_waddr   = r_tos;
        w_wdata   = push_addr_i;
        w_ovf_set = 1'b0;
        if (restore_i) begin
            w_tos_nxt = restore_ptr_i;
`ifdef RAS_TOP_REPAIR_EN
            w_we      = 1'b1;
            w_waddr   = restore_ptr_i;
            w_wdata   = restore_tgt_i;
`endif
        end else if (push_i && pop_i) begin
            // coroutine swap: the pop already consumed the old top this cycle
            w_we      = 1'b1;
        end else if (push_i) begin
            w_tos_nxt = w_tos_inc;
            w_we      = 1'b1;
            w_waddr   = w_tos_inc;
            w_ovf_set = r_vld[w_tos_inc];
        end else if (pop_i) begin
            // popped entries are kept so a later restore can recover them
            w_tos_nxt = r_tos - LOGDEPTH'(1);
        end else begin
            w_tos_nxt = r_tos;
        end
    end

    // pointer, valid bits and sticky overflow flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tos <= {LOGDEPTH{1'b0}};
            r_vld <= {DEPTH{1'b0}};
            r_ovf <= 1'b0;
        end else begin
            r_tos <= w_tos_nxt;
            if (w_we) begin
                r_vld[w_waddr] <= 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    ram_dp #(
        .DEPTH    (DEPTH),
        .LOGDEPTH (LOGDEPTH),
        .AW       (AW)
    ) u_mem (
        .clock    (clock),
        .reset    (reset),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr  (r_tos),
        .o_rdata  (ras_tgt_o)
    );

    assign ras_ptr_o   = r_tos;
    assign ras_valid_o = r_vld[r_tos];
    assign ras_ovf_o   = r_ovf;
endmodule

// File: doc/ras_stack.md
# ras_stack

Return Address Stack for the fetch stage. It predicts return targets and checkpoints its top-of-stack pointer into the branch ordering buffer on every predicted branch. On misprediction it rewinds to the checkpointed pointer read back from that buffer. It sits beside the F1 PC mux: it is pushed on predicted calls, popped on predicted returns, and restored by the commit/recovery path.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two.
- LOGDEPTH, 4, pointer width; must match the buffer's 4-bit rasptr field.
- AW, 64, address width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- push_i  input  1  predicted call (BSR/JSR) in F1
- pop_i  input  1  predicted return (RET) in F1
- push_addr_i  input  AW  return address to store (call PC + 4)
- restore_i  input  1  misprediction recovery
- restore_ptr_i  input  LOGDEPTH  checkpointed pointer from the buffer's rasptr output
- ras_ptr_o  output  LOGDEPTH  current top-of-stack pointer; written into the buffer's rasptr input
- ras_tgt_o  output  AW  predicted return target = mem[tos]
- ras_valid_o  output  1  entry at tos holds a pushed address
- ras_ovf_o  output  1  sticky: a push has overwritten a valid entry by wrap-around

## Operation
- State: mem[DEPTH] of AW bits, vld[DEPTH] bits, tos pointer (LOGDEPTH bits), ovf flag.
- Reset: tos=0, all mem=0, all vld=0, ovf=0. Outputs after reset: ras_ptr_o=0, ras_tgt_o=0, ras_valid_o=0, ras_ovf_o=0.
- Priority per cycle: restore_i > (push_i & pop_i) > push_i > pop_i.
- restore_i: tos <= restore_ptr_i. mem and vld are unchanged. push_i and pop_i are ignored that cycle.
- push only: tos <= tos+1 (mod DEPTH); mem[tos+1] <= push_addr_i; vld[tos+1] <= 1. If vld[tos+1] was already 1, ovf <= 1.
- pop only: tos <= tos-1 (mod DEPTH). mem and vld are unchanged, so a later restore can recover popped entries. ras_tgt_o for the pop is the pre-pop mem[tos].
- push & pop (JSR_COROUTINE): mem[tos] <= push_addr_i; vld[tos] <= 1; tos unchanged. The target used for the pop is the old mem[tos].
- Pop with ras_valid_o=0 (underflow): pointer still decrements. Fetch ignores ras_tgt_o whenever ras_valid_o=0.
- Wrap-around: the pointer is modulo DEPTH in both directions. There is no full or empty stall; the oldest entry is silently overwritten.
- ovf is cleared only by reset.

## Timing
- ras_tgt_o, ras_valid_o and ras_ptr_o are combinational from registered state. They are valid in the same cycle as pop_i, so F1 can redirect with zero added latency.
- All updates take effect on the next rising clock edge. A push in cycle N is visible on ras_tgt_o in cycle N+1.
- ras_ptr_o sampled in cycle N is the pre-update pointer. The buffer checkpoints this value alongside the branch written in cycle N.
- Reset asserted mid-operation clears all state immediately (asynchronous). Release is taken synchronously by the next edge.

## Configuration
- RAS_TOP_REPAIR_EN defined:
  - Adds input restore_tgt_i [AW-1:0].
  - On restore_i: mem[restore_ptr_i] <= restore_tgt_i and vld[restore_ptr_i] <= 1. This repairs a top entry corrupted by wrong-path push-after-pop.
- Not defined:
  - No extra port.
  - Restore rewinds only the pointer.

## Structure
- Shared fetch package holds:
  - RAS_DEPTH=16, RAS_LOGDEPTH=4
  - the rasptr_t typedef, shared with the branch ordering buffer so the widths stay locked
  - the address-width constant
- Storage uses the existing dual-port RAM wrapper as one natural sub-module, ram_dp:
  - one combinational read port at tos
  - one write port
- vld, tos and ovf stay as flops in ras_stack.

## Test plan
- Reset: assert reset mid-run after 3 pushes -> ras_ptr_o=0, ras_valid_o=0, ras_tgt_o=0, ras_ovf_o=0 with no clock edge needed.
- LIFO: push 0x1004, push 0x2008, pop, pop -> targets 0x2008 then 0x1004; ras_ptr_o sequence 0,1,2,1,0.
- Coroutine: push 0x1004, then push&pop with 0x3000 -> pop target 0x1004; ras_ptr_o stays 1; next pop target 0x3000.
- Restore: ptr=3, pop twice (ptr=1), restore_i with restore_ptr_i=3 -> ras_ptr_o=3 and ras_tgt_o equals the original entry 3; a simultaneous push is ignored.
- Wrap: 17 pushes of 0x100+4k (k=0..16) -> ras_ptr_o=1, ras_ovf_o=1, ras_tgt_o=0x140; 16 pops then yield ras_valid_o=1 on all entries.
- Underflow/repair: from reset, pop -> ras_ptr_o=15, ras_valid_o=0. With RAS_TOP_REPAIR_EN, restore ptr 2 with restore_tgt_i 0xABC0 -> ras_tgt_o=0xABC0, ras_valid_o=1.
